// File: rtl/ber_window_monitor_if.sv
// ---------------------------------------------------------------------------
// ber_window_monitor_if
//   Signal bundle between a BER monitor and the logic that feeds and reads it.
//   The master side (stimulus / link test controller) drives the sample pair,
//   alignment delay, clear and threshold. The slave side (the monitor) returns
//   the cumulative and per-window error results.
//
//   clear       master->slave  synchronous counter clear, active-high
//   en          master->slave  sample-valid qualifier for ref_in/rx_in
//   ref_in      master->slave  transmitted reference sample (WIDTH)
//   rx_in       master->slave  received sample (WIDTH)
//   delay_sel   master->slave  reference alignment delay in cycles (DLY_W)
//   threshold   master->slave  window alarm threshold (WERR_W)
//   errors      slave->master  cumulative bit errors, saturating (CNT_W)
//   error_flag  slave->master  sticky saturation flag
//   win_errors  slave->master  error count of last completed window (WERR_W)
//   win_valid   slave->master  one-cycle pulse when win_errors updates
//   alarm       slave->master  last window result exceeded threshold
// ---------------------------------------------------------------------------
interface ber_window_monitor_if #(
  parameter int WIDTH  = 12,
  parameter int CNT_W  = 50,
  parameter int WERR_W = 20,
  parameter int DLY_W  = 3
);
  logic              clear;
  logic              en;
  logic [WIDTH-1:0]  ref_in;
  logic [WIDTH-1:0]  rx_in;
  logic [DLY_W-1:0]  delay_sel;
  logic [WERR_W-1:0] threshold;
  logic [CNT_W-1:0]  errors;
  logic              error_flag;
  logic [WERR_W-1:0] win_errors;
  logic              win_valid;
  logic              alarm;

  modport master (
    output clear, en, ref_in, rx_in, delay_sel, threshold,
    input  errors, error_flag, win_errors, win_valid, alarm
  );

  modport slave (
    input  clear, en, ref_in, rx_in, delay_sel, threshold,
    output errors, error_flag, win_errors, win_valid, alarm
  );
endinterface

// File: rtl/ber_window_monitor.sv
// ---------------------------------------------------------------------------
// ber_window_monitor
//   Bit-error-rate monitor for the audio link loopback. The reference stream
//   is aligned to the link latency by a tapped delay line, XORed with the
//   received stream, popcounted, and accumulated into a saturating cumulative
//   counter plus per-window counters (2^WIN_LOG2 enabled samples per window)
//   with a threshold alarm.
//
//   CLK    in   single clock, rising edge
//   reset  in   synchronous active-low reset (priority over clear)
//   mon    slave modport of ber_window_monitor_if (sample pair, delay,
//          clear, threshold in; errors, error_flag, win_errors, win_valid,
//          alarm out)
//
//   Latency: a pair captured at edge n is reflected in the counters after
//   edge n+2.
// ---------------------------------------------------------------------------
module ber_window_monitor #(
  parameter int WIDTH    = 12,
  parameter int CNT_W    = 50,
  parameter int WIN_LOG2 = 16,
  parameter int WERR_W   = 20,
  parameter int DLY_W    = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  ber_window_monitor_if.slave  mon
);

  localparam int                DEPTH    = (1 << DLY_W) - 1;
  localparam int                PC_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WERR_W-1:0] WERR_MAX = '1;

  // Delay line and alignment tap
  logic [WIDTH-1:0]    r_dly [DEPTH];
  logic [WIDTH-1:0]    w_ref_d;

  // Stage 1 / stage 2 pipeline
  logic [WIDTH-1:0]    r_diff;
  logic                r_v1;
  logic [PC_W-1:0]     w_pc;
  logic [PC_W-1:0]     r_pc;
  logic                r_v2;

  // Accumulators and results
  logic [CNT_W-1:0]    r_errors;
  logic                r_error_flag;
  logic [WERR_W-1:0]   r_win_acc;
  logic [WIN_LOG2-1:0] r_sample_cnt;
  logic [WERR_W-1:0]   r_win_errors;
  logic                r_win_valid;
  logic                r_alarm;

  logic [CNT_W:0]      w_err_sum;
  logic [CNT_W-1:0]    w_err_sat;
  logic [WERR_W:0]     w_win_sum;
  logic [WERR_W-1:0]   w_win_sat;
  logic                w_win_last;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ref_d = mon.ref_in;
    if (mon.delay_sel != '0) begin
      w_ref_d = r_dly[mon.delay_sel - DLY_W'(1)];
    end
  end

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pc = w_pc + PC_W'(r_diff[i]);
    end
  end

  // One spare bit on each sum catches overflow; overflow clamps to all-ones.
  assign w_err_sum  = {1'b0, r_errors} + (CNT_W+1)'(r_pc);
  assign w_err_sat  = w_err_sum[CNT_W] ? CNT_MAX : w_err_sum[CNT_W-1:0];
  assign w_win_sum  = {1'b0, r_win_acc} + (WERR_W+1)'(r_pc);
  assign w_win_sat  = w_win_sum[WERR_W] ? WERR_MAX : w_win_sum[WERR_W-1:0];
  assign w_win_last = &r_sample_cnt;

  // The delay line shifts every cycle regardless of en or clear, so the
  // alignment survives gaps and counter clears. Only reset flushes it.
  // NOTE: this storage array is reset on purpose: after reset the tap must
  // present zeros, not stale samples, until the line refills.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_dly[0] <= mon.ref_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!reset || mon.clear) begin
      // Reset and clear zero the same pipeline/counter state; clear also wins
      // over a window completion on the same edge, so no pulse escapes.
      r_diff       <= '0;
      r_v1         <= 1'b0;
      r_pc         <= '0;
      r_v2         <= 1'b0;
      r_errors     <= '0;
      r_error_flag <= 1'b0;
      r_win_acc    <= '0;
      r_sample_cnt <= '0;
      r_win_errors <= '0;
      r_win_valid  <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_diff      <= w_ref_d ^ mon.rx_in;
      r_v1        <= mon.en;
      r_pc        <= w_pc;
      r_v2        <= r_v1;
      r_win_valid <= 1'b0;

      if (r_v2) begin
        r_errors <= w_err_sat;
        if (w_err_sat == CNT_MAX) begin
          r_error_flag <= 1'b1;
        end

        r_sample_cnt <= r_sample_cnt + WIN_LOG2'(1);
        if (w_win_last) begin
          r_win_errors <= w_win_sat;
          r_alarm      <= (w_win_sat > mon.threshold);
          r_win_valid  <= 1'b1;
          r_win_acc    <= '0;
        end else begin
          r_win_acc    <= w_win_sat;
        end
      end
    end
  end

  assign mon.errors     = r_errors;
  assign mon.error_flag = r_error_flag;
  assign mon.win_errors = r_win_errors;
  assign mon.win_valid  = r_win_valid;
  assign mon.alarm      = r_alarm;

endmodule

// File: tb/tb_ber_window_monitor.sv
// ---------------------------------------------------------------------------
// tb_ber_window_monitor
//   Two monitors share one stimulus stream: 'a' with the wide default
//   counters, 'b' with a 6-bit cumulative counter and 7-bit window counter so
//   saturation is reached quickly. Both use 16-sample windows. A sample-level
//   reference model tracks each instance and every output is compared after
//   each clock edge; directed sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_ber_window_monitor;

  logic        CLK;
  logic        reset;
  logic        clear;
  logic        en;
  logic [11:0] ref_in;
  logic [11:0] rx_in;
  logic [2:0]  dsel;
  int          thr;

  ber_window_monitor_if #(.WIDTH(12), .CNT_W(50), .WERR_W(20), .DLY_W(3)) if_a ();
  ber_window_monitor_if #(.WIDTH(12), .CNT_W(6),  .WERR_W(7),  .DLY_W(3)) if_b ();

  assign if_a.clear     = clear;
  assign if_a.en        = en;
  assign if_a.ref_in    = ref_in;
  assign if_a.rx_in     = rx_in;
  assign if_a.delay_sel = dsel;
  assign if_a.threshold = 20'(thr);
  assign if_b.clear     = clear;
  assign if_b.en        = en;
  assign if_b.ref_in    = ref_in;
  assign if_b.rx_in     = rx_in;
  assign if_b.delay_sel = dsel;
  assign if_b.threshold = 7'(thr);

  ber_window_monitor #(.WIDTH(12), .CNT_W(50), .WIN_LOG2(4), .WERR_W(20), .DLY_W(3)) dut_a (
    .CLK   (CLK),
    .reset (reset),
    .mon   (if_a.slave)
  );

  ber_window_monitor #(.WIDTH(12), .CNT_W(6), .WIN_LOG2(4), .WERR_W(7), .DLY_W(3)) dut_b (
    .CLK   (CLK),
    .reset (reset),
    .mon   (if_b.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint unsigned errors;
    bit              flag;
    longint unsigned win_acc;
    int              cnt;
    longint unsigned win_err;
    bit              alarm;
    bit              win_valid;
  } mstate_t;

  localparam int WIN_LEN = 16;

  mstate_t         m [2];
  longint unsigned cmax [2];
  longint unsigned wmax [2];
  logic [11:0]     hist [7];   // ref_in history, hist[0] = previous cycle
  bit              pv [2];     // samples in flight: [0] newest, [1] lands next
  int              ppc [2];

  task automatic model_step();
    logic [11:0]     rd;
    int              pcn;
    longint unsigned acc;
    if (!reset) begin
      for (int j = 0; j < 2; j++) m[j] = '{default: 0};
      for (int k = 0; k < 7; k++) hist[k] = '0;
      pv[0] = 0; pv[1] = 0;
    end else begin
      rd  = (dsel == 3'd0) ? ref_in : hist[int'(dsel) - 1];
      pcn = $countones(rd ^ rx_in);
      for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ref_in;
      if (clear) begin
        for (int j = 0; j < 2; j++) m[j] = '{default: 0};
        pv[0] = 0; pv[1] = 0;
      end else begin
        for (int j = 0; j < 2; j++) begin
          m[j].win_valid = 0;
          if (pv[1]) begin
            m[j].errors = m[j].errors + longint'(ppc[1]);
            if (m[j].errors > cmax[j]) m[j].errors = cmax[j];
            if (m[j].errors == cmax[j]) m[j].flag = 1;
            acc = m[j].win_acc + longint'(ppc[1]);
            if (acc > wmax[j]) acc = wmax[j];
            m[j].cnt++;
            if (m[j].cnt == WIN_LEN) begin
              m[j].win_err   = acc;
              m[j].alarm     = (acc > longint'(thr));
              m[j].win_valid = 1;
              m[j].win_acc   = 0;
              m[j].cnt       = 0;
            end else begin
              m[j].win_acc   = acc;
            end
          end
        end
        pv[1] = pv[0]; ppc[1] = ppc[0];
        pv[0] = en;    ppc[0] = pcn;
      end
    end
  endtask

  task automatic compare_all();
    check("a.errors",     64'(if_a.errors),     m[0].errors);
    check("a.error_flag", 64'(if_a.error_flag), 64'(m[0].flag));
    check("a.win_errors", 64'(if_a.win_errors), m[0].win_err);
    check("a.win_valid",  64'(if_a.win_valid),  64'(m[0].win_valid));
    check("a.alarm",      64'(if_a.alarm),      64'(m[0].alarm));
    check("b.errors",     64'(if_b.errors),     m[1].errors);
    check("b.error_flag", 64'(if_b.error_flag), 64'(m[1].flag));
    check("b.win_errors", 64'(if_b.win_errors), m[1].win_err);
    check("b.win_valid",  64'(if_b.win_valid),  64'(m[1].win_valid));
    check("b.alarm",      64'(if_b.alarm),      64'(m[1].alarm));
  endtask

  // ---------------- stimulus helpers ----------------
  int          tick_no = 0;
  int          pulse_t [$];
  int          wins_a  [$];
  int          alarms_a[$];
  int          wins_b  [$];
  logic [11:0] txh [8];       // bench-side record of driven ref_in values

  task automatic tick();
    @(posedge CLK);
    tick_no++;
    model_step();
    for (int k = 7; k > 0; k--) txh[k] = txh[k-1];
    txh[0] = ref_in;
    #1;
    compare_all();
    if (if_a.win_valid) begin
      pulse_t.push_back(tick_no);
      wins_a.push_back(int'(if_a.win_errors));
      alarms_a.push_back(int'(if_a.alarm));
    end
    if (if_b.win_valid) wins_b.push_back(int'(if_b.win_errors));
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic drive(input int n, input logic [11:0] mask);
    for (int i = 0; i < n; i++) begin
      en     = 1'b1;
      ref_in = 12'($urandom);
      rx_in  = ref_in ^ mask;
      tick();
    end
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en     = 1'b0;
      ref_in = 12'($urandom);
      rx_in  = 12'($urandom);
      tick();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    en    = 1'b0;
    tick();
    clear = 1'b0;
    pulse_t.delete();
    wins_a.delete();
    alarms_a.delete();
    wins_b.delete();
  endtask

  // ---------------- test sequence ----------------
  int exp_b [8] = '{0, 0, 12, 24, 36, 48, 60, 63};

  initial begin
    cmax[0] = (64'd1 << 50) - 64'd1;
    cmax[1] = 64'd63;
    wmax[0] = (64'd1 << 20) - 64'd1;
    wmax[1] = 64'd127;
    for (int k = 0; k < 8; k++) txh[k] = '0;
    reset = 1'b0; clear = 1'b0; en = 1'b0;
    ref_in = '0; rx_in = '0; dsel = '0; thr = 0;

    // Reset state
    tick(); tick();
    check("rst.errors",     64'(if_a.errors),     0);
    check("rst.error_flag", 64'(if_a.error_flag), 0);
    check("rst.win_errors", 64'(if_a.win_errors), 0);
    check("rst.win_valid",  64'(if_a.win_valid),  0);
    check("rst.alarm",      64'(if_a.alarm),      0);
    reset = 1'b1;

    // Identical streams: two clean windows, 16 cycles apart
    do_clear();
    drive(32, 12'h000);
    idle(3);
    check("t1.pulses",  64'(pulse_t.size()), 2);
    check("t1.spacing", 64'(qget(pulse_t, 1) - qget(pulse_t, 0)), 16);
    check("t1.errors",  64'(if_a.errors), 0);
    check("t1.win",     64'(qget(wins_a, 1)), 0);
    check("t1.alarm",   64'(if_a.alarm), 0);

    // One bad bit per sample, then twelve
    do_clear();
    drive(16, 12'h001);
    drive(16, 12'hFFF);
    idle(3);
    check("t2.win1",   64'(qget(wins_a, 0)), 16);
    check("t2.win2",   64'(qget(wins_a, 1)), 192);
    check("t2.errors", 64'(if_a.errors), 208);
    check("t2.b_win2", 64'(qget(wins_b, 1)), 127);
    check("t2.b_err",  64'(if_b.errors), 63);
    check("t2.b_flag", 64'(if_b.error_flag), 1);

    // Alignment: rx is ref delayed by 3 cycles
    do_clear();
    dsel = 3'd3;
    idle(8);
    for (int i = 0; i < 40; i++) begin
      en = 1'b1; ref_in = 12'($urandom); rx_in = txh[2]; tick();
    end
    idle(3);
    check("t3.aligned", 64'(if_a.errors), 0);
    dsel = 3'd2;
    for (int i = 0; i < 40; i++) begin
      en = 1'b1; ref_in = 12'($urandom); rx_in = txh[2]; tick();
    end
    idle(3);
    check("t3.misaligned", 64'(if_a.errors != '0), 1);
    dsel = 3'd0;

    // Saturation of the 6-bit counter
    do_clear();
    for (int k = 0; k < 8; k++) begin
      drive(1, 12'hFFF);
      check($sformatf("t4.err%0d", k), 64'(if_b.errors), 64'(exp_b[k]));
      check($sformatf("t4.flag%0d", k), 64'(if_b.error_flag), (k == 7) ? 64'd1 : 64'd0);
    end
    drive(4, 12'hFFF);
    idle(2);
    check("t4.hold_err",  64'(if_b.errors), 63);
    check("t4.hold_flag", 64'(if_b.error_flag), 1);
    do_clear();
    check("t4.clr_err",  64'(if_b.errors), 0);
    check("t4.clr_flag", 64'(if_b.error_flag), 0);

    // Threshold boundary: 11 > 10 alarms, 10 does not
    thr = 10;
    do_clear();
    drive(11, 12'h001); drive(5, 12'h000);
    drive(10, 12'h001); drive(6, 12'h000);
    idle(3);
    check("t5.win1",   64'(qget(wins_a, 0)), 11);
    check("t5.alarm1", 64'(qget(alarms_a, 0)), 1);
    check("t5.win2",   64'(qget(wins_a, 1)), 10);
    check("t5.alarm2", 64'(qget(alarms_a, 1)), 0);

    // Reset mid-window discards the partial window
    do_clear();
    drive(5, 12'h001);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("t6.rst_err",   64'(if_a.errors), 0);
    check("t6.rst_win",   64'(if_a.win_errors), 0);
    check("t6.rst_alarm", 64'(if_a.alarm), 0);
    drive(15, 12'h001);
    idle(3);
    check("t6.no_pulse", 64'(pulse_t.size()), 0);
    drive(1, 12'h001);
    idle(3);
    check("t6.pulse", 64'(pulse_t.size()), 1);
    check("t6.win",   64'(qget(wins_a, 0)), 16);

    // Clear on the window-completing edge suppresses the pulse
    do_clear();
    drive(16, 12'h001);
    idle(1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t7.valid", 64'(if_a.win_valid), 0);
    check("t7.win",   64'(if_a.win_errors), 0);
    idle(3);
    check("t7.no_pulse", 64'(pulse_t.size()), 0);

    // Randomized traffic against the model
    thr = 20;
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(3) != 0);
      ref_in = 12'($urandom);
      case ($urandom_range(3))
        0:       rx_in = ref_in;
        1:       rx_in = ref_in ^ (12'd1 << $urandom_range(11));
        2:       rx_in = ~ref_in;
        default: rx_in = 12'($urandom);
      endcase
      if ($urandom_range(49) == 0)  dsel = 3'($urandom);
      if ($urandom_range(99) == 0)  thr = int'($urandom_range(127));
      clear = ($urandom_range(199) == 0);
      reset = ($urandom_range(399) != 0);
      tick();
    end
    clear = 1'b0;
    reset = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/ber_window_monitor.md
# ber_window_monitor

Parametrised bit-error-rate monitor for the audio link test chain (A-law/BPSK loopback). It compares a transmitted reference word stream against the received, decompressed stream over WIDTH-bit samples. A programmable delay aligns the reference to the link latency. It keeps a saturating cumulative error count and per-window error counts with a threshold alarm. It is the successor to the fixed 12-bit BER counter used in the loopback top level and sits beside the codec pipeline, fed by the same sample enable.

## Interface
- WIDTH, 12: sample width in bits.
- CNT_W, 50: cumulative error counter width.
- WIN_LOG2, 16: window length is 2^WIN_LOG2 enabled samples.
- WERR_W, 20: per-window error count width.
- DLY_W, 3: delay select width; delay range is 0..2^DLY_W-1 cycles.

- CLK  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous counter clear, active-high.
- en  in  1  sample-valid qualifier for ref_in/rx_in.
- ref_in  in  WIDTH  transmitted reference sample.
- rx_in  in  WIDTH  received sample.
- delay_sel  in  DLY_W  reference alignment delay in CLK cycles.
- threshold  in  WERR_W  window alarm threshold.
- errors  out  CNT_W  cumulative bit errors, saturating.
- error_flag  out  1  sticky; set when errors reaches 2^CNT_W-1.
- win_errors  out  WERR_W  error count of the last completed window.
- win_valid  out  1  one-cycle pulse when win_errors updates.
- alarm  out  1  registered with each window result: win_errors > threshold.

## Operation
- Delay line: the shift register of depth 2^DLY_W-1 loads ref_in every cycle, independent of en. ref_d is the tap at delay_sel. delay_sel=0 means ref_d = ref_in. A change to delay_sel takes effect immediately, and the line is not flushed.
- Stage 1 (registered): diff <= ref_d ^ rx_in; v1 <= en.
- Stage 2 (registered): pc <= popcount(diff), width clog2(WIDTH+1); v2 <= v1.
- Stage 3 (accumulate, when v2=1):
  - errors <= min(errors+pc, 2^CNT_W-1). error_flag is set on the same edge the sum reaches max and stays set until reset or clear.
  - win_acc <= min(win_acc+pc, 2^WERR_W-1); sample_cnt (WIN_LOG2 bits) increments.
  - When sample_cnt = 2^WIN_LOG2-1:
    - win_errors <= saturated win_acc+pc
    - alarm <= (that value > threshold)
    - win_valid <= 1
    - win_acc <= 0, sample_cnt <= 0 (wrap-around).
- win_valid is 0 in every other cycle. win_errors and alarm hold between windows.
- When v2=0, all accumulators hold.
- clear=1 has the following effect:
  - zeroes errors, error_flag, win_acc, sample_cnt, win_errors, alarm, win_valid, v1, v2.
  - The delay line keeps shifting.
  - clear has priority over a window completion on the same edge, so no win_valid is produced.
- reset=0 zeroes every register, including the delay line and v1/v2. reset has priority over clear. A window in progress is discarded.

## Timing
- Reset values are 0 for errors, error_flag, win_errors, win_valid and alarm.
- A pair captured at edge n (en=1) is reflected in errors and win_acc after edge n+2.
- The last sample of a window captured at edge n produces win_valid high during the cycle after edge n+2, together with the updated win_errors and alarm.
- Sustained throughput is one sample per cycle. en may toggle arbitrarily, and gaps do not affect counts.
- With delay_sel=d, ref_in at cycle n is compared with rx_in at cycle n+d.
- Saturation is sticky: errors stays at max until clear or reset, and further errors are ignored.

## Test plan
- Identical streams, WIN_LOG2=4, en=1 for 32 cycles, delay_sel=0 → errors=0, two win_valid pulses 16 cycles apart, win_errors=0, alarm=0.
- rx_in = ref_in ^ 12'h001 for 16 samples, then ^ 12'hFFF for 16, WIN_LOG2=4 → window 1 win_errors=16, window 2 win_errors=192, errors=208.
- Random ref_in, rx_in = ref_in delayed 3 cycles externally, delay_sel=3 → errors=0. Repeat with delay_sel=2 → errors>0.
- CNT_W=6, rx_in = ~ref_in → errors 12,24,36,48,60, then 63 on the 6th sample with error_flag=1 on that edge. Both hold thereafter. clear → both 0.
- threshold=10, WIN_LOG2=4: window with 11 errors → alarm=1; next window with exactly 10 errors → alarm=0.
- reset low for one cycle mid-window → all outputs 0 after that edge, and the next window needs a full 16 samples. clear asserted on the window-completing edge → win_valid stays 0 and win_errors=0.
